dcache_ctrl: RTL and testbench

//  Direct-mapped, write-back, write-allocate data cache between the CPU and data memory.

---
 rtl/dcache_ctrl_if.sv | 26 ++
 rtl/dcache_ctrl.sv | 118 +++++++++++
 tb/tb_dcache_ctrl.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/dcache_ctrl_if.sv
// CPU-side request/response and memory-side block transfer signals of the data cache.
// slave is the cache's view; master is the view of whatever drives the CPU and memory.
interface dcache_ctrl_if;
  logic        read;
  logic        write;
  logic [7:0]  address;
  logic [7:0]  writedata;
  logic [7:0]  readdata;
  logic        busywait;
  logic        mem_read;
  logic        mem_write;
  logic [5:0]  mem_address;
  logic [31:0] mem_writedata;
  logic [31:0] mem_readdata;
  logic        mem_busywait;

  modport slave (
    input  read, write, address, writedata, mem_readdata, mem_busywait,
    output readdata, busywait, mem_read, mem_write, mem_address, mem_writedata
  );

  modport master (
    output read, write, address, writedata, mem_readdata, mem_busywait,
    input  readdata, busywait, mem_read, mem_write, mem_address, mem_writedata
  );
endinterface

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate data cache with 4-byte blocks.
// Stalls the CPU through busywait while a dirty block is written back and a new one fetched.
module dcache_ctrl #(
  parameter int unsigned IndexBits = 3
) (
  input  logic         clk_i,
  input  logic         rst_i,
  dcache_ctrl_if.slave bus
);

  localparam int unsigned TagBits   = 6 - IndexBits;
  localparam int unsigned NumBlocks = 1 << IndexBits;

  typedef enum logic [1:0] {StIdle, StWb, StFetch, StRefill} state_e;

  state_e                state_q;
  logic [NumBlocks-1:0]  valid_q;
  logic [NumBlocks-1:0]  dirty_q;
  logic [TagBits-1:0]    tag_q  [NumBlocks];
  logic [31:0]           data_q [NumBlocks];
  logic                  mem_read_q;
  logic                  mem_write_q;
  logic [5:0]            mem_address_q;
  logic [31:0]           mem_writedata_q;
  logic [5:0]            miss_addr_q;
  logic [31:0]           fill_q;

  logic [TagBits-1:0]    addr_tag;
  logic [IndexBits-1:0]  addr_idx;
  logic [1:0]            addr_off;
  logic [TagBits-1:0]    miss_tag;
  logic [IndexBits-1:0]  miss_idx;
  logic                  req;
  logic                  hit;

  assign addr_tag = bus.address[7 -: TagBits];
  assign addr_idx = bus.address[2 +: IndexBits];
  assign addr_off = bus.address[1:0];
  assign miss_tag = miss_addr_q[5 -: TagBits];
  assign miss_idx = miss_addr_q[IndexBits-1:0];

  assign req = bus.read | bus.write;
  assign hit = valid_q[addr_idx] && (tag_q[addr_idx] == addr_tag);

  // Gated by reset so an aborted miss releases the CPU in the same cycle.
  assign bus.busywait      = !rst_i && ((state_q != StIdle) || (req && !hit));
  assign bus.readdata      = data_q[addr_idx][{addr_off, 3'b000} +: 8];
  assign bus.mem_read      = mem_read_q;
  assign bus.mem_write     = mem_write_q;
  assign bus.mem_address   = mem_address_q;
  assign bus.mem_writedata = mem_writedata_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q         <= StIdle;
      valid_q         <= '0;
      dirty_q         <= '0;
      mem_read_q      <= 1'b0;
      mem_write_q     <= 1'b0;
      mem_address_q   <= '0;
      mem_writedata_q <= '0;
      miss_addr_q     <= '0;
      fill_q          <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req && hit) begin
            if (bus.write) dirty_q[addr_idx] <= 1'b1;
          end else if (req) begin
            miss_addr_q <= {addr_tag, addr_idx};
            if (dirty_q[addr_idx]) begin
              state_q         <= StWb;
              mem_write_q     <= 1'b1;
              mem_address_q   <= {tag_q[addr_idx], addr_idx};
              mem_writedata_q <= data_q[addr_idx];
            end else begin
              state_q       <= StFetch;
              mem_read_q    <= 1'b1;
              mem_address_q <= {addr_tag, addr_idx};
            end
          end
        end
        StWb: begin
          if (!bus.mem_busywait) begin
            state_q       <= StFetch;
            mem_write_q   <= 1'b0;
            mem_read_q    <= 1'b1;
            mem_address_q <= miss_addr_q;
          end
        end
        StFetch: begin
          if (!bus.mem_busywait) begin
            state_q    <= StRefill;
            mem_read_q <= 1'b0;
            fill_q     <= bus.mem_readdata;
          end
        end
        StRefill: begin
          state_q           <= StIdle;
          valid_q[miss_idx] <= 1'b1;
          dirty_q[miss_idx] <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Tag and data arrays carry no reset; validity alone qualifies their contents.
  always_ff @(posedge clk_i) begin
    if (!rst_i && state_q == StRefill) begin
      data_q[miss_idx] <= fill_q;
      tag_q[miss_idx]  <= miss_tag;
    end else if (!rst_i && state_q == StIdle && bus.write && hit) begin
      data_q[addr_idx][{addr_off, 3'b000} +: 8] <= bus.writedata;
    end
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed bench for dcache_ctrl: misses, hits, dirty evictions, abort by reset, RW priority.
// A small block memory model answers with a programmable busy latency.
module tb_dcache_ctrl;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_err;
  int   mem_lat;

  dcache_ctrl_if bus ();

  dcache_ctrl dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] mem_q [64];
  logic [63:0] mem_v = '0;
  int          cnt;
  int          wb_cnt = 0;
  logic [5:0]  last_wb_addr;
  logic [31:0] last_wb_data;

  function automatic logic [31:0] init_word(input logic [5:0] a);
    case (a)
      6'h00:   return 32'h44332211;
      6'h08:   return 32'h88776655;
      6'h11:   return 32'hDDCCBBAA;
      default: return 32'h0;
    endcase
  endfunction

  assign bus.mem_busywait = (bus.mem_read || bus.mem_write) && (cnt < mem_lat);
  assign bus.mem_readdata = mem_v[bus.mem_address] ? mem_q[bus.mem_address]
                                                   : init_word(bus.mem_address);

  always @(posedge clk) begin
    if (rst || !(bus.mem_read || bus.mem_write)) begin
      cnt <= 0;
    end else if (cnt >= mem_lat) begin
      cnt <= 0;
      if (bus.mem_write) begin
        mem_q[bus.mem_address] <= bus.mem_writedata;
        mem_v[bus.mem_address] <= 1'b1;
        wb_cnt                 <= wb_cnt + 1;
        last_wb_addr           <= bus.mem_address;
        last_wb_data           <= bus.mem_writedata;
      end
    end else begin
      cnt <= cnt + 1;
    end
  end

  // Counts busywait cycles from the current sample point; no comparisons here.
  task automatic wait_busy(output int n, output logic [5:0] faddr, output logic sf,
                           output logic sw, output logic both);
    n = 0; faddr = '0; sf = 0; sw = 0; both = 0;
    #1;
    while (bus.busywait && n < 100) begin
      n++;
      if (bus.mem_read && !sf) begin
        sf    = 1;
        faddr = bus.mem_address;
      end
      if (bus.mem_write) sw = 1;
      if (bus.mem_read && bus.mem_write) both = 1;
      @(negedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    rst = 1; bus.read = 0; bus.write = 0; bus.address = '0; bus.writedata = '0;
    @(negedge clk);
    #1;
    n_checks++; if (bus.busywait !== 1'b0) begin n_err++;
      $display("FAIL reset_busywait got %b want 0", bus.busywait); end
    n_checks++; if (bus.mem_read !== 1'b0) begin n_err++;
      $display("FAIL reset_mem_read got %b want 0", bus.mem_read); end
    n_checks++; if (bus.mem_write !== 1'b0) begin n_err++;
      $display("FAIL reset_mem_write got %b want 0", bus.mem_write); end
    n_checks++; if (bus.mem_address !== 6'h00) begin n_err++;
      $display("FAIL reset_mem_address got %h want 00", bus.mem_address); end
    n_checks++; if (bus.mem_writedata !== 32'h0) begin n_err++;
      $display("FAIL reset_mem_writedata got %h want 0", bus.mem_writedata); end
    @(negedge clk);
    rst = 0;
  endtask

  task automatic test_read_miss();
    int n; logic [5:0] fa; logic sf, sw, both;
    mem_lat = 5;
    @(negedge clk);
    bus.read = 1; bus.address = 8'h00;
    wait_busy(n, fa, sf, sw, both);
    n_checks++; if (n !== 8) begin n_err++;
      $display("FAIL rmiss_cycles got %0d want 8", n); end
    n_checks++; if (!sf || fa !== 6'h00) begin n_err++;
      $display("FAIL rmiss_fetch got seen=%b addr=%h want seen=1 addr=00", sf, fa); end
    n_checks++; if (sw !== 1'b0) begin n_err++;
      $display("FAIL rmiss_no_wb got %b want 0", sw); end
    n_checks++; if (bus.readdata !== 8'h11) begin n_err++;
      $display("FAIL rmiss_data got %h want 11", bus.readdata); end
    @(negedge clk);
    bus.address = 8'h03;
    #1;
    n_checks++; if (bus.busywait !== 1'b0) begin n_err++;
      $display("FAIL rhit_busy got %b want 0", bus.busywait); end
    n_checks++; if (bus.readdata !== 8'h44) begin n_err++;
      $display("FAIL rhit_data got %h want 44", bus.readdata); end
    @(negedge clk);
    bus.read = 0;
  endtask

  task automatic test_write_hit();
    @(negedge clk);
    bus.write = 1; bus.address = 8'h01; bus.writedata = 8'hAB;
    #1;
    n_checks++; if (bus.busywait !== 1'b0) begin n_err++;
      $display("FAIL whit_busy got %b want 0", bus.busywait); end
    n_checks++; if (bus.mem_read !== 1'b0 || bus.mem_write !== 1'b0) begin n_err++;
      $display("FAIL whit_mem got rd=%b wr=%b want 0 0", bus.mem_read, bus.mem_write); end
    @(negedge clk);
    bus.write = 0; bus.read = 1;
    #1;
    n_checks++; if (bus.readdata !== 8'hAB || bus.busywait !== 1'b0) begin n_err++;
      $display("FAIL whit_readback got %h busy=%b want AB busy=0", bus.readdata, bus.busywait);
    end
    @(negedge clk);
    bus.read = 0;
  endtask

  task automatic test_dirty_evict();
    int n; logic [5:0] fa; logic sf, sw, both; int wbc0;
    wbc0 = wb_cnt;
    @(negedge clk);
    bus.read = 1; bus.address = 8'h20;
    wait_busy(n, fa, sf, sw, both);
    n_checks++; if (n !== 14) begin n_err++;
      $display("FAIL evict_cycles got %0d want 14", n); end
    n_checks++; if (!sw || wb_cnt !== wbc0 + 1) begin n_err++;
      $display("FAIL evict_wb got seen=%b cnt=%0d want seen=1 cnt=%0d", sw, wb_cnt, wbc0 + 1);
    end
    n_checks++; if (last_wb_addr !== 6'h00 || last_wb_data !== 32'h4433AB11) begin n_err++;
      $display("FAIL evict_wb_block got %h:%h want 00:4433ab11", last_wb_addr, last_wb_data);
    end
    n_checks++; if (!sf || fa !== 6'h08) begin n_err++;
      $display("FAIL evict_fetch got seen=%b addr=%h want 1 08", sf, fa); end
    n_checks++; if (both !== 1'b0) begin n_err++;
      $display("FAIL evict_rd_wr_overlap got %b want 0", both); end
    n_checks++; if (bus.readdata !== 8'h55) begin n_err++;
      $display("FAIL evict_data got %h want 55", bus.readdata); end
    @(negedge clk);
    bus.read = 0;
  endtask

  task automatic test_write_miss();
    int n; logic [5:0] fa; logic sf, sw, both;
    logic [7:0] addrs [3];
    logic [7:0] exp [3];
    addrs = '{8'h45, 8'h44, 8'h47};
    exp   = '{8'h5A, 8'hAA, 8'hDD};
    mem_lat = 2;
    @(negedge clk);
    bus.write = 1; bus.address = 8'h45; bus.writedata = 8'h5A;
    wait_busy(n, fa, sf, sw, both);
    n_checks++; if (n !== 5) begin n_err++;
      $display("FAIL wmiss_cycles got %0d want 5", n); end
    n_checks++; if (!sf || fa !== 6'h11 || sw) begin n_err++;
      $display("FAIL wmiss_fetch got seen=%b addr=%h wb=%b want 1 11 0", sf, fa, sw); end
    @(negedge clk);
    bus.write = 0; bus.read = 1;
    for (int i = 0; i < 3; i++) begin
      bus.address = addrs[i];
      #1;
      n_checks++; if (bus.readdata !== exp[i]) begin n_err++;
        $display("FAIL wmiss_byte addr=%h got %h want %h", addrs[i], bus.readdata, exp[i]); end
      @(negedge clk);
    end
    bus.address = 8'h25;
    wait_busy(n, fa, sf, sw, both);
    n_checks++; if (n !== 8) begin n_err++;
      $display("FAIL wmiss_evict_cycles got %0d want 8", n); end
    n_checks++; if (last_wb_addr !== 6'h11 || last_wb_data !== 32'hDDCC5AAA) begin n_err++;
      $display("FAIL wmiss_dirty_wb got %h:%h want 11:ddcc5aaa", last_wb_addr, last_wb_data);
    end
    n_checks++; if (fa !== 6'h09) begin n_err++;
      $display("FAIL wmiss_evict_fetch got %h want 09", fa); end
    @(negedge clk);
    bus.read = 0;
  endtask

  task automatic test_reset_mid_fetch();
    int n; logic [5:0] fa; logic sf, sw, both;
    mem_lat = 5;
    @(negedge clk);
    bus.read = 1; bus.address = 8'h00;
    @(negedge clk);
    #1;
    n_checks++; if (bus.mem_read !== 1'b1 || bus.busywait !== 1'b1) begin n_err++;
      $display("FAIL abort_in_fetch got rd=%b busy=%b want 1 1", bus.mem_read, bus.busywait);
    end
    @(negedge clk);
    rst = 1;
    #1;
    n_checks++; if (bus.mem_read !== 1'b0 || bus.busywait !== 1'b0) begin n_err++;
      $display("FAIL abort_drop got rd=%b busy=%b want 0 0", bus.mem_read, bus.busywait); end
    @(negedge clk);
    rst = 0;
    wait_busy(n, fa, sf, sw, both);
    n_checks++; if (n !== 8 || !sf || fa !== 6'h00) begin n_err++;
      $display("FAIL abort_remiss got cyc=%0d addr=%h want 8 00", n, fa); end
    n_checks++; if (bus.readdata !== 8'h11) begin n_err++;
      $display("FAIL abort_data got %h want 11", bus.readdata); end
    @(negedge clk);
    bus.read = 0;
  endtask

  task automatic test_rw_priority();
    @(negedge clk);
    bus.read = 1; bus.write = 1; bus.address = 8'h02; bus.writedata = 8'h77;
    #1;
    n_checks++; if (bus.busywait !== 1'b0 || bus.mem_read || bus.mem_write) begin n_err++;
      $display("FAIL rw_hit got busy=%b rd=%b wr=%b want 0 0 0",
               bus.busywait, bus.mem_read, bus.mem_write);
    end
    @(negedge clk);
    bus.write = 0;
    #1;
    n_checks++; if (bus.readdata !== 8'h77) begin n_err++;
      $display("FAIL rw_written got %h want 77", bus.readdata); end
    @(negedge clk);
    bus.address = 8'h03;
    #1;
    n_checks++; if (bus.readdata !== 8'h44) begin n_err++;
      $display("FAIL rw_neighbour got %h want 44", bus.readdata); end
    @(negedge clk);
    bus.read = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    n_checks = 0;
    n_err    = 0;
    mem_lat  = 5;
    test_reset();
    test_read_miss();
    test_write_hit();
    test_dirty_evict();
    test_write_miss();
    test_reset_mid_fetch();
    test_rw_priority();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
